riscv_mem_arbiter: RTL
======================

Name: riscv_mem_arbiter

Overview:
- Shares one single-port unified memory between the RV32I core's instruction-fetch port and its load/store data port.
- Serialises requests as one outstanding transaction at a time.
- Arbitration is data-priority with a bounded fetch-starvation guard, plus a read-response timeout.
- Sits between the core's instr/data buses and the memory model/SRAM wrapper; the testbench observes both sides.

Parameters:
- MAX_STREAK, 4: maximum consecutive data grants while if_req is pending; legal range 1..15.
- TIMEOUT, 64: cycles allowed in WAIT_RESP before an error completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_done=1.
- if_done  out  1  single-cycle completion pulse.
- if_err  out  1  error pulse, coincident with if_done.
- d_req  in  1  data request, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid while d_done=1.
- d_done  out  1  single-cycle completion pulse.
- d_err  out  1  error pulse, coincident with d_done.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - streak counter and timeout counter to 0.
- Reset mid-transaction abandons it; a later mem_rvalid that arrives while in IDLE is dropped.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - A requester whose done output is 1 this cycle is not eligible.
  - Winner selection: d_req wins unless if_req=1 and streak==MAX_STREAK; then fetch wins.
  - The winner's fields are latched into the memory outputs: mem_addr={addr[31:2],2'b00}.
  - For fetch: mem_we=0, mem_be=4'hF, mem_wdata=0.
  - For data: mem_we=d_we, mem_be = d_we ? d_be : 4'hF.
  - After latching, set mem_req=1 and go to ISSUE.
- Fetch with if_addr[1:0]!=0: no memory access; if_done=1, if_err=1 and if_rdata=0 next cycle; FSM stays in IDLE.
- Streak counter:
  - Increments on a data grant made while if_req=1; saturates at MAX_STREAK.
  - Clears on a fetch grant, or on a data grant made with if_req=0.
- ISSUE:
  - mem_* fields stay stable while mem_ready=0; there is no timeout here.
  - On mem_req & mem_ready: drop mem_req.
    - Write: pulse d_done next cycle, go to IDLE.
    - Read: go to WAIT_RESP, timeout counter = 0.
- WAIT_RESP:
  - On mem_rvalid: the owner's rdata = mem_rdata, done=1 next cycle, go to IDLE.
  - Otherwise the counter increments. Once it reaches TIMEOUT (TIMEOUT>0): done=1, err=1, rdata=0, go to IDLE.
  - mem_rvalid in the same cycle the timeout fires: mem_rvalid wins and there is no error.
- mem_rvalid outside WAIT_RESP is ignored.
- rdata holds its value after done; done and err are single-cycle pulses.
- Minimum read latency, with mem_ready=1 and mem_rvalid one cycle after acceptance:
  - cycle 0: req sampled;
  - cycle 1: mem_req;
  - cycle 2: mem_rvalid;
  - cycle 3: done.
- Minimum write latency: req at cycle 0, d_done at cycle 2.
- A requester that drops req before done is a protocol violation; the transaction completes on the latched fields regardless.

Decomposition:
- Package riscv_mem_pkg holds:
  - arb_state_e {IDLE, ISSUE, WAIT_RESP};
  - owner_e {OWN_IF, OWN_D};
  - the constant BE_ALL=4'hF.
- One sub-module, riscv_arb_picker: combinational winner selection plus the streak counter register.

Test Plan:
- Fetch only: if_addr=32'h100, mem_ready=1, mem_rdata=32'h00500093 one cycle after acceptance -> if_done at cycle 3, if_rdata=32'h00500093, mem_addr=32'h100, mem_we=0.
- Store: d_we=1, d_be=4'b0011, d_addr=32'h2002, d_wdata=32'hDEAD_BEEF -> mem_addr=32'h2000, mem_be=4'b0011; d_done at cycle 2; no mem_rvalid required.
- Starvation guard: d_req and if_req both held continuously, MAX_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Timeout: load issued, mem_rvalid never asserted, TIMEOUT=8 -> d_done=1, d_err=1, d_rdata=0; 8 cycles after entering WAIT_RESP the FSM returns to IDLE.
- Misaligned fetch: if_addr=32'h102 -> if_done=1, if_err=1 next cycle; mem_req stays 0.
- Reset mid-read: rst=0 in WAIT_RESP, then mem_rvalid after release -> all outputs 0, busy=0, no done pulse.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types and constants for the RV32I unified-memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which core port owns the transaction in flight
//   BE_ALL      : full-word byte enable used for every read
//   word_align  : clears the byte offset of an address
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter_if
// Bundles the core's instruction-fetch port, its load/store port and the
// single-port memory port that the arbiter sits between.
//   slave  : the arbiter's view (takes core requests, drives the memory)
//   master : the environment's view (core plus memory model)
// ---------------------------------------------------------------------------
interface riscv_mem_arbiter_if;

  // instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;

  // load/store port
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;

  // memory port
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done, if_err,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_done, d_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done, if_err,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_done, d_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/riscv_arb_picker.sv
// ---------------------------------------------------------------------------
// riscv_arb_picker
// Winner selection for the arbiter plus the fetch-starvation streak counter.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   if_req, d_req   : raw requests from the two core ports
//   if_elig, d_elig : port is not completing this cycle
//   grant_en        : arbiter is idle and may start a transaction
//   grant           : a transaction starts this cycle
//   winner          : port that owns it
// ---------------------------------------------------------------------------
module riscv_arb_picker
  import riscv_mem_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   if_elig,
  input  logic   d_elig,
  input  logic   grant_en,
  output logic   grant,
  output owner_e winner
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] streak_q;
  logic [3:0] streak_d;

  // The winner is chosen from the raw requests; if that port is still
  // completing its previous transaction the grant waits one cycle rather
  // than falling through to the other port. This keeps a continuously
  // requesting data port ahead of fetch until the streak limit is hit.
  always_comb begin
    winner = OWN_D;
    if (if_req && (!d_req || (streak_q == STREAK_MAX))) begin
      winner = OWN_IF;
    end

    if (winner == OWN_IF) begin
      grant = grant_en && if_req && if_elig;
    end else begin
      grant = grant_en && d_req && d_elig;
    end

    streak_d = streak_q;
    if (grant) begin
      if ((winner == OWN_IF) || !if_req) begin
        streak_d = 4'd0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak_q <= 4'd0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one single-port memory between the RV32I fetch and load/store
// ports, one transaction at a time. Data has priority; fetch is granted
// after MAX_STREAK consecutive data grants made while it waited. Reads that
// see no mem_rvalid within TIMEOUT cycles complete with an error
// (TIMEOUT = 0 waits forever). All outputs are registered.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : fetch, load/store and memory ports (riscv_mem_arbiter_if.slave)
//   busy : FSM not in IDLE
// ---------------------------------------------------------------------------
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  riscv_mem_arbiter_if.slave bus,
  output logic               busy
);

  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [3:0]    mem_be_q,    mem_be_d;
  logic [31:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q,  if_rdata_d;
  logic          if_done_q,   if_done_d;
  logic          if_err_q,    if_err_d;
  logic [31:0]   d_rdata_q,   d_rdata_d;
  logic          d_done_q,    d_done_d;
  logic          d_err_q,     d_err_d;
  logic          busy_q,      busy_d;

  logic          grant;
  owner_e        winner;
  logic          if_misaligned;
  logic          accept;
  logic          rsp;
  logic          tmo_fire;

  riscv_arb_picker #(
    .MAX_STREAK (MAX_STREAK)
  ) u_picker (
    .clk      (clk),
    .rst      (rst),
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .if_elig  (!if_done_q),
    .d_elig   (!d_done_q),
    .grant_en (state_q == IDLE),
    .grant    (grant),
    .winner   (winner)
  );

  // A misaligned fetch is answered locally with an error and never
  // reaches the memory.
  assign if_misaligned = (winner == OWN_IF) && (bus.if_addr[1:0] != 2'b00);
  assign accept        = (state_q == ISSUE) && mem_req_q && bus.mem_ready;
  assign rsp           = (state_q == WAIT_RESP) && bus.mem_rvalid;
  // mem_rvalid in the firing cycle takes precedence over the timeout.
  assign tmo_fire      = (state_q == WAIT_RESP) && !bus.mem_rvalid &&
                         (TIMEOUT > 0) && (tmo_q == TMO_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant && !if_misaligned) state_d = ISSUE;
      end
      ISSUE: begin
        if (accept) state_d = mem_we_q ? IDLE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (rsp || tmo_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath register inputs
  always_comb begin
    owner_d     = owner_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant) begin
          if (winner == OWN_IF) begin
            if (if_misaligned) begin
              if_done_d  = 1'b1;
              if_err_d   = 1'b1;
              if_rdata_d = 32'h0;
            end else begin
              owner_d     = OWN_IF;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_be_d    = BE_ALL;
              mem_addr_d  = word_align(bus.if_addr);
              mem_wdata_d = 32'h0;
            end
          end else begin
            owner_d     = OWN_D;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.d_we;
            mem_be_d    = bus.d_we ? bus.d_be : BE_ALL;
            mem_addr_d  = word_align(bus.d_addr);
            mem_wdata_d = bus.d_wdata;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          mem_req_d = 1'b0;
          tmo_d     = '0;
          // only the data port ever writes
          if (mem_we_q) d_done_d = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (bus.mem_rvalid) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus.mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            d_rdata_d = bus.mem_rdata;
            d_done_d  = 1'b1;
          end
        end else if (tmo_fire) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = 32'h0;
            if_done_d  = 1'b1;
            if_err_d   = 1'b1;
          end else begin
            d_rdata_d = 32'h0;
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
          end
        end else if (TIMEOUT > 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      d_rdata_q   <= d_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_err     = d_err_q;
  assign busy          = busy_q;

endmodule
